// File: rtl/fetch_pc_table_if.sv
// rtl/fetch_pc_table_if.sv - fetch/ROB side signal bundle of the fetch PC table
interface fetch_pc_table_if #(
    parameter int ID_W   = 5,
    parameter int DATA_W = 59
);
    logic              IN_wrValid;
    logic [DATA_W-1:0] IN_wrData;
    logic              OUT_wrReady;
    logic [ID_W-1:0]   OUT_wrFetchID;
    logic [ID_W-1:0]   IN_curFetchID;
    logic [ID_W-1:0]   IN_rdAddr;
    logic [DATA_W-1:0] OUT_rdData;
    logic              OUT_rdValid;
    logic              IN_redirValid;
    logic [ID_W-1:0]   IN_redirFetchID;
    logic [ID_W:0]     OUT_occupancy;

    modport master (
        output IN_wrValid, IN_wrData, IN_curFetchID, IN_rdAddr, IN_redirValid, IN_redirFetchID,
        input  OUT_wrReady, OUT_wrFetchID, OUT_rdData, OUT_rdValid, OUT_occupancy
    );

    modport slave (
        input  IN_wrValid, IN_wrData, IN_curFetchID, IN_rdAddr, IN_redirValid, IN_redirFetchID,
        output OUT_wrReady, OUT_wrFetchID, OUT_rdData, OUT_rdValid, OUT_occupancy
    );
endinterface

// File: rtl/fetch_pc_table.sv
// rtl/fetch_pc_table.sv - fetch-ID indexed PC/predictor table with redirect rewind and retire
module fetch_pc_table #(
    parameter int NUM_ENTRIES = 32,
    parameter int ID_W        = 5,
    parameter int DATA_W      = 59
) (
    input logic              clk,
    input logic              rst,
    fetch_pc_table_if.slave  bus
);
    logic [DATA_W-1:0]      data_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [ID_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [ID_W-1:0]        prev_cur_q;
    logic [ID_W:0]          occ_q, occ_cnt;
    logic                   wr_ready, wr_fire;

    // True when i lies strictly between a and b walking forward (mod NUM_ENTRIES).
    function automatic logic in_range(input logic [ID_W-1:0] a, input logic [ID_W-1:0] b,
                                      input logic [ID_W-1:0] i);
        logic [ID_W-1:0] di, db;
        di = i - a;
        db = b - a;
        return (di != '0) && (di < db);
    endfunction

    // The slot at the committed ID stays reserved, which also disambiguates full from empty.
    assign wr_ready = (wr_ptr_q != bus.IN_curFetchID) && !bus.IN_redirValid && !rst;
    assign wr_fire  = bus.IN_wrValid && wr_ready;

    always_comb begin
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (in_range(prev_cur_q, bus.IN_curFetchID, ID_W'(i)) ||
                (bus.IN_redirValid && in_range(bus.IN_redirFetchID, wr_ptr_q, ID_W'(i)))) begin
                valid_d[i] = 1'b0;
            end
        end
        if (bus.IN_redirValid) begin
            wr_ptr_d = bus.IN_redirFetchID + ID_W'(1);
        end else if (wr_fire) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + ID_W'(1);
        end
    end

    always_comb begin
        occ_cnt = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            occ_cnt = occ_cnt + (ID_W+1)'(valid_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            valid_q    <= '0;
            prev_cur_q <= '1;
            occ_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            valid_q    <= valid_d;
            prev_cur_q <= bus.IN_curFetchID;
            occ_q      <= occ_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            data_q[wr_ptr_q] <= bus.IN_wrData;
        end
    end

    assign bus.OUT_wrReady   = wr_ready;
    assign bus.OUT_wrFetchID = wr_ptr_q;
    assign bus.OUT_rdData    = data_q[bus.IN_rdAddr];
    assign bus.OUT_rdValid   = valid_q[bus.IN_rdAddr] && !rst;
    assign bus.OUT_occupancy = occ_q;
endmodule

// File: tb/tb_fetch_pc_table.sv
// tb/tb_fetch_pc_table.sv - directed and randomized checks of fetch_pc_table against a table model
module tb_fetch_pc_table;
    logic clk;
    logic rst;

    fetch_pc_table_if #(.ID_W(5), .DATA_W(59)) bus ();

    fetch_pc_table #(.NUM_ENTRIES(32), .ID_W(5), .DATA_W(59)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    logic [58:0] m_data [32];
    bit          m_written [32];
    bit          m_valid [32];
    logic [4:0]  m_ptr;
    logic [4:0]  m_prev;
    int          m_occ;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit between(input logic [4:0] a, input logic [4:0] b, input logic [4:0] i);
        logic [4:0] da, db;
        da = i - a;
        db = b - a;
        return (da != 5'd0) && (da < db);
    endfunction

    task automatic model_edge();
        bit  nv [32];
        int  cnt;
        bit  fire;
        if (rst) begin
            m_ptr  = 5'd0;
            m_prev = 5'd31;
            m_occ  = 0;
            for (int i = 0; i < 32; i++) m_valid[i] = 0;
        end else begin
            cnt = 0;
            for (int i = 0; i < 32; i++) cnt += int'(m_valid[i]);
            fire = bus.IN_wrValid && (m_ptr != bus.IN_curFetchID) && !bus.IN_redirValid;
            for (int i = 0; i < 32; i++) begin
                nv[i] = m_valid[i];
                if (between(m_prev, bus.IN_curFetchID, 5'(i))) nv[i] = 0;
                if (bus.IN_redirValid && between(bus.IN_redirFetchID, m_ptr, 5'(i))) nv[i] = 0;
            end
            if (fire) begin
                nv[m_ptr]        = 1;
                m_data[m_ptr]    = bus.IN_wrData;
                m_written[m_ptr] = 1;
            end
            if (bus.IN_redirValid) m_ptr = bus.IN_redirFetchID + 5'd1;
            else if (fire) m_ptr = m_ptr + 5'd1;
            m_prev = bus.IN_curFetchID;
            m_occ  = cnt;
            for (int i = 0; i < 32; i++) m_valid[i] = nv[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wrReady", 64'(bus.OUT_wrReady),
                64'((m_ptr != bus.IN_curFetchID) && !bus.IN_redirValid && !rst));
            chk("wrFetchID", 64'(bus.OUT_wrFetchID), 64'(m_ptr));
            chk("rdValid", 64'(bus.OUT_rdValid), 64'(!rst && m_valid[bus.IN_rdAddr]));
            if (m_written[bus.IN_rdAddr])
                chk("rdData", 64'(bus.OUT_rdData), 64'(m_data[bus.IN_rdAddr]));
            chk("occupancy", 64'(bus.OUT_occupancy), 64'(m_occ));
        end
    end

    task automatic rand_data();
        logic [63:0] r64;
        r64 = {$urandom, $urandom};
        bus.IN_wrData = r64[58:0];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.IN_wrValid    = 1'b0;
        bus.IN_redirValid = 1'b0;
        bus.IN_curFetchID = 5'd31;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic write_n(input int n);
        bus.IN_wrValid = 1'b1;
        for (int i = 0; i < n; i++) begin
            rand_data();
            tick();
        end
        bus.IN_wrValid = 1'b0;
    endtask

    task automatic lit_valid(input logic [4:0] addr, input bit exp, input string nm);
        bus.IN_rdAddr = addr;
        #1;
        chk(nm, 64'(bus.OUT_rdValid), 64'(exp));
    endtask

    initial begin
        logic [4:0] k5;
        for (int i = 0; i < 32; i++) m_written[i] = 0;
        rst                 = 1'b1;
        bus.IN_wrValid      = 1'b0;
        bus.IN_wrData       = '0;
        bus.IN_curFetchID   = 5'd31;
        bus.IN_rdAddr       = 5'd0;
        bus.IN_redirValid   = 1'b0;
        bus.IN_redirFetchID = 5'd0;
        tick();
        chk_en = 1;
        do_reset();
        chk("reset_occ", 64'(bus.OUT_occupancy), 64'd0);
        chk("reset_ptr", 64'(bus.OUT_wrFetchID), 64'd0);
        chk("reset_ready", 64'(bus.OUT_wrReady), 64'd1);

        // Fill: 31 usable entries, 32nd write dropped
        write_n(31);
        chk("fill_ready", 64'(bus.OUT_wrReady), 64'd0);
        chk("fill_ptr", 64'(bus.OUT_wrFetchID), 64'd31);
        bus.IN_wrValid = 1'b1;
        tick();
        bus.IN_wrValid = 1'b0;
        chk("fill_occ", 64'(bus.OUT_occupancy), 64'd31);
        chk("fill_drop_ptr", 64'(bus.OUT_wrFetchID), 64'd31);

        // Read has no write bypass
        do_reset();
        write_n(5);
        bus.IN_wrValid = 1'b1;
        bus.IN_wrData  = 59'h1234567;
        bus.IN_rdAddr  = 5'd5;
        #1;
        chk("nobypass_valid", 64'(bus.OUT_rdValid), 64'd0);
        tick();
        bus.IN_wrValid = 1'b0;
        #1;
        chk("wr5_data", 64'(bus.OUT_rdData), 64'h1234567);
        chk("wr5_valid", 64'(bus.OUT_rdValid), 64'd1);

        // Redirect rewinds pointer and kills younger blocks
        write_n(4);
        chk("pre_redir_ptr", 64'(bus.OUT_wrFetchID), 64'd10);
        bus.IN_redirValid   = 1'b1;
        bus.IN_redirFetchID = 5'd6;
        bus.IN_wrValid      = 1'b1;
        #1;
        chk("redir_ready", 64'(bus.OUT_wrReady), 64'd0);
        tick();
        bus.IN_redirValid = 1'b0;
        bus.IN_wrValid    = 1'b0;
        chk("redir_ptr", 64'(bus.OUT_wrFetchID), 64'd7);
        lit_valid(5'd6, 1'b1, "redir_keep6");
        lit_valid(5'd7, 1'b0, "redir_kill7");
        lit_valid(5'd9, 1'b0, "redir_kill9");

        // Redirect wrapping past the top
        do_reset();
        write_n(30);
        bus.IN_curFetchID = 5'd28;
        tick();
        bus.IN_redirValid   = 1'b1;
        bus.IN_redirFetchID = 5'd31;
        tick();
        bus.IN_redirValid = 1'b0;
        chk("wrap_ptr", 64'(bus.OUT_wrFetchID), 64'd0);
        write_n(1);
        chk("wrap_ptr1", 64'(bus.OUT_wrFetchID), 64'd1);
        lit_valid(5'd0, 1'b1, "wrap_valid0");
        write_n(40);
        chk("wrap_stall_ptr", 64'(bus.OUT_wrFetchID), 64'd28);
        chk("wrap_stall_ready", 64'(bus.OUT_wrReady), 64'd0);

        // Multi-entry retire frees a full table
        do_reset();
        write_n(31);
        bus.IN_curFetchID = 5'd3;
        #1;
        chk("retire_ready", 64'(bus.OUT_wrReady), 64'd1);
        tick();
        lit_valid(5'd0, 1'b0, "retire_kill0");
        lit_valid(5'd2, 1'b0, "retire_kill2");
        lit_valid(5'd3, 1'b1, "retire_keep3");

        // Retire and redirect in the same cycle
        do_reset();
        write_n(12);
        bus.IN_curFetchID = 5'd2;
        tick();
        bus.IN_curFetchID   = 5'd4;
        bus.IN_redirValid   = 1'b1;
        bus.IN_redirFetchID = 5'd8;
        tick();
        bus.IN_redirValid = 1'b0;
        chk("both_ptr", 64'(bus.OUT_wrFetchID), 64'd9);
        lit_valid(5'd3, 1'b0, "both_kill3");
        lit_valid(5'd4, 1'b1, "both_keep4");
        lit_valid(5'd8, 1'b1, "both_keep8");
        lit_valid(5'd9, 1'b0, "both_kill9");
        lit_valid(5'd11, 1'b0, "both_kill11");

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst                 = ($urandom_range(0, 199) == 0);
            bus.IN_wrValid      = ($urandom_range(0, 9) < 7);
            rand_data();
            bus.IN_rdAddr       = 5'($urandom);
            bus.IN_redirValid   = ($urandom_range(0, 15) == 0);
            bus.IN_redirFetchID = m_ptr - 5'd1 - 5'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                k5 = m_ptr - bus.IN_curFetchID;
                if (k5 > 5'd1)
                    bus.IN_curFetchID = bus.IN_curFetchID + 5'($urandom_range(1, int'(k5) - 1));
            end
            if (rst) bus.IN_curFetchID = 5'd31;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
